// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the ID-stage hazard controller.
//   sb_entry_t   : one scoreboard slot {valid, rd, is_load}
//   ctrl_state_e : counter-attribution state (RUN / HAZARD / MEMWAIT)
//   sb_match     : true when a slot holds a live write to a non-x0 register
package pipe_hazard_ctrl_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HAZARD  = 2'd1,
    ST_MEMWAIT = 2'd2
  } ctrl_state_e;

  // x0 is hard-wired zero, so it can never create a dependency.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] addr);
    return e.valid && (e.rd == addr) && (addr != 5'd0);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage <-> hazard controller bundle.
//   master : drives the decoded-instruction fields, branch resolution and mem_busy
//   slave  : the controller; returns stalls, flush, issue, PC redirect and counters
// PC_WIDTH / CNT_WIDTH must match the parameters of the attached controller.
interface pipe_hazard_ctrl_if #(
  parameter int PC_WIDTH  = 10,
  parameter int CNT_WIDTH = 16
);
  logic                 id_valid;
  logic                 rs1_re;
  logic [4:0]           rs1_addr;
  logic                 rs2_re;
  logic [4:0]           rs2_addr;
  logic                 rd_we;
  logic [4:0]           rd_addr;
  logic                 id_is_load;
  logic                 ex_branch_taken;
  logic [PC_WIDTH-1:0]  ex_target;
  logic                 mem_busy;
  logic                 stall_if;
  logic                 stall_id;
  logic                 stall_ex;
  logic                 flush_id;
  logic                 issue;
  logic                 pc_redirect_en;
  logic [PC_WIDTH-1:0]  pc_redirect;
  logic [CNT_WIDTH-1:0] haz_cycles;
  logic [CNT_WIDTH-1:0] mem_cycles;

  modport master (
    output id_valid, rs1_re, rs1_addr, rs2_re, rs2_addr, rd_we, rd_addr, id_is_load,
           ex_branch_taken, ex_target, mem_busy,
    input  stall_if, stall_id, stall_ex, flush_id, issue, pc_redirect_en, pc_redirect,
           haz_cycles, mem_cycles
  );

  modport slave (
    input  id_valid, rs1_re, rs1_addr, rs2_re, rs2_addr, rd_we, rd_addr, id_is_load,
           ex_branch_taken, ex_target, mem_busy,
    output stall_if, stall_id, stall_ex, flush_id, issue, pc_redirect_en, pc_redirect,
           haz_cycles, mem_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sb_shift.sv
// One scoreboard slot register.
//   clk, rst (sync, active-low)
//   hold      : keep current contents (data-memory freeze)
//   bubble    : load an empty slot instead of entry_in
//   entry_in  : value from the previous (younger) slot or the ID insert
//   entry_out : registered slot contents
module sb_shift
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      bubble,
  input  sb_entry_t entry_in,
  output sb_entry_t entry_out
);
  sb_entry_t entry_d, entry_q;

  always_comb begin
    entry_d = entry_q;
    if (!hold) begin
      entry_d = bubble ? '0 : entry_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) entry_q <= '0;
    else      entry_q <= entry_d;
  end

  assign entry_out = entry_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage pipeline sequencer for the 5-stage RV32I core.
//   clk, rst (sync, active-low; all outputs forced to 0 while low)
//   bus (slave): ID read/write requests, EX branch resolution, mem_busy in;
//                stall_if/id/ex, flush_id, issue, pc_redirect(_en) and the
//                saturating haz_cycles / mem_cycles counters out.
// Scoreboard slot [0]=EX, [1]=MEM, [2]=WB. Priority: mem_busy > branch > hazard > issue.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int PC_WIDTH  = 10,
  parameter int SB_DEPTH  = 3,
  parameter int FWD_EN    = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  sb_entry_t           sb_q [SB_DEPTH];
  sb_entry_t           ins_entry;
  logic                bubble;
  logic                hit1, hit2, hazard;
  logic                stall_if_c, stall_id_c, stall_ex_c, flush_c, issue_c, redir_en_c;
  logic [PC_WIDTH-1:0] redir_c;

  ctrl_state_e          state_d, state_q;
  logic [CNT_WIDTH-1:0] haz_d, haz_q, mem_d, mem_q;

  // Scoreboard shift chain; the whole chain freezes on mem_busy.
  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_sb
    if (gi == 0) begin : g_head
      sb_shift u_sb (
        .clk      (clk),
        .rst      (rst),
        .hold     (bus.mem_busy),
        .bubble   (bubble),
        .entry_in (ins_entry),
        .entry_out(sb_q[gi])
      );
    end else begin : g_tail
      sb_shift u_sb (
        .clk      (clk),
        .rst      (rst),
        .hold     (bus.mem_busy),
        .bubble   (1'b0),
        .entry_in (sb_q[gi-1]),
        .entry_out(sb_q[gi])
      );
    end
  end

  // With forwarding only a load still in EX cannot be bypassed. Without it,
  // every in-flight writer except the WB slot blocks: WB writes the regfile
  // in the same cycle and the regfile reads through the new value.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (FWD_EN != 0) begin
      hit1 = sb_match(sb_q[0], bus.rs1_addr) && sb_q[0].is_load;
      hit2 = sb_match(sb_q[0], bus.rs2_addr) && sb_q[0].is_load;
    end else begin
      for (int i = 0; i < SB_DEPTH - 1; i++) begin
        hit1 = hit1 | sb_match(sb_q[i], bus.rs1_addr);
        hit2 = hit2 | sb_match(sb_q[i], bus.rs2_addr);
      end
    end
    hazard = bus.id_valid && ((bus.rs1_re && hit1) || (bus.rs2_re && hit2));
  end

  always_comb begin
    stall_if_c = 1'b0;
    stall_id_c = 1'b0;
    stall_ex_c = 1'b0;
    flush_c    = 1'b0;
    issue_c    = 1'b0;
    redir_en_c = 1'b0;
    redir_c    = '0;
    bubble     = 1'b0;
    if (bus.mem_busy) begin
      stall_if_c = 1'b1;
      stall_id_c = 1'b1;
      stall_ex_c = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // The ID instruction is on the wrong path, so any hazard it has is moot.
      redir_en_c = 1'b1;
      redir_c    = bus.ex_target;
      flush_c    = 1'b1;
      bubble     = 1'b1;
    end else if (hazard) begin
      stall_if_c = 1'b1;
      stall_id_c = 1'b1;
      bubble     = 1'b1;
    end else begin
      issue_c = bus.id_valid;
    end
    ins_entry         = '0;
    ins_entry.valid   = issue_c && bus.rd_we && (bus.rd_addr != 5'd0);
    ins_entry.rd      = bus.rd_addr;
    ins_entry.is_load = bus.id_is_load;
  end

  // Counter attribution state lags the stall decision by one cycle.
  always_comb begin
    if (bus.mem_busy)                          state_d = ST_MEMWAIT;
    else if (hazard && !bus.ex_branch_taken)   state_d = ST_HAZARD;
    else                                       state_d = ST_RUN;
    haz_d = haz_q;
    mem_d = mem_q;
    if (state_q == ST_HAZARD && !(&haz_q))  haz_d = haz_q + CNT_ONE;
    if (state_q == ST_MEMWAIT && !(&mem_q)) mem_d = mem_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      haz_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      haz_q   <= haz_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.stall_if       = rst & stall_if_c;
  assign bus.stall_id       = rst & stall_id_c;
  assign bus.stall_ex       = rst & stall_ex_c;
  assign bus.flush_id       = rst & flush_c;
  assign bus.issue          = rst & issue_c;
  assign bus.pc_redirect_en = rst & redir_en_c;
  assign bus.pc_redirect    = {PC_WIDTH{rst}} & redir_c;
  assign bus.haz_cycles     = {CNT_WIDTH{rst}} & haz_q;
  assign bus.mem_cycles     = {CNT_WIDTH{rst}} & mem_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share one stimulus stream:
//   u_a : FWD_EN=0, CNT_WIDTH=4  (no-forwarding hazards, freeze, branch, saturation)
//   u_b : FWD_EN=1, CNT_WIDTH=16 (load-use)
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 0, rs1_re = 0, rs2_re = 0, rd_we = 0, id_is_load = 0;
  logic [4:0] rs1_addr = 0, rs2_addr = 0, rd_addr = 0;
  logic       ex_branch_taken = 0, mem_busy = 0;
  logic [9:0] ex_target = 0;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.PC_WIDTH(10), .CNT_WIDTH(4))  if_a ();
  pipe_hazard_ctrl_if #(.PC_WIDTH(10), .CNT_WIDTH(16)) if_b ();

  assign if_a.id_valid = id_valid;   assign if_b.id_valid = id_valid;
  assign if_a.rs1_re = rs1_re;       assign if_b.rs1_re = rs1_re;
  assign if_a.rs1_addr = rs1_addr;   assign if_b.rs1_addr = rs1_addr;
  assign if_a.rs2_re = rs2_re;       assign if_b.rs2_re = rs2_re;
  assign if_a.rs2_addr = rs2_addr;   assign if_b.rs2_addr = rs2_addr;
  assign if_a.rd_we = rd_we;         assign if_b.rd_we = rd_we;
  assign if_a.rd_addr = rd_addr;     assign if_b.rd_addr = rd_addr;
  assign if_a.id_is_load = id_is_load; assign if_b.id_is_load = id_is_load;
  assign if_a.ex_branch_taken = ex_branch_taken; assign if_b.ex_branch_taken = ex_branch_taken;
  assign if_a.ex_target = ex_target; assign if_b.ex_target = ex_target;
  assign if_a.mem_busy = mem_busy;   assign if_b.mem_busy = mem_busy;

  pipe_hazard_ctrl #(.PC_WIDTH(10), .SB_DEPTH(3), .FWD_EN(0), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst(rst_n), .bus(if_a.slave)
  );
  pipe_hazard_ctrl #(.PC_WIDTH(10), .SB_DEPTH(3), .FWD_EN(1), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst_n), .bus(if_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: apply on the falling edge, settle, log the transaction.
  task automatic cyc(input string name, input logic rn, input logic v,
                     input logic r1e, input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
                     input logic we, input logic [4:0] rd, input logic ld,
                     input logic br, input logic [9:0] tgt, input logic mb);
    @(negedge clk);
    rst_n = rn; id_valid = v; rs1_re = r1e; rs1_addr = r1; rs2_re = r2e; rs2_addr = r2;
    rd_we = we; rd_addr = rd; id_is_load = ld; ex_branch_taken = br; ex_target = tgt;
    mem_busy = mb;
    #1;
    $display("t=%0t %s: rst=%0b v=%0b rs1=%0d rs2=%0d rd=%0d br=%0b mb=%0b | a: iss=%0b stl=%0b haz=%0d mem=%0d | b: iss=%0b stl=%0b haz=%0d",
             $time, name, rn, v, r1, r2, rd, br, mb, if_a.issue, if_a.stall_id,
             if_a.haz_cycles, if_a.mem_cycles, if_b.issue, if_b.stall_id, if_b.haz_cycles);
  endtask

  task automatic idle(input string name);
    cyc(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h0, 0);
  endtask

  task automatic do_reset();
    cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h0, 0);
  endtask

  initial begin
    // 1: reset with live inputs, then release
    cyc("rst0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 10'h1A4, 0);
    chk("rst_issue", if_a.issue, 0);
    chk("rst_redir_en", if_a.pc_redirect_en, 0);
    chk("rst_redir", if_a.pc_redirect, 0);
    chk("rst_flush", if_a.flush_id, 0);
    cyc("rst1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 10'h1A4, 0);
    chk("rst_issue_b", if_b.issue, 0);
    chk("rst_redir_en_b", if_b.pc_redirect_en, 0);
    cyc("run0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h0, 0);
    chk("run_issue_a", if_a.issue, 1);
    chk("run_issue_b", if_b.issue, 1);
    chk("run_haz_a", if_a.haz_cycles, 0);
    chk("run_mem_a", if_a.mem_cycles, 0);
    chk("run_haz_b", if_b.haz_cycles, 0);

    // 2: load-use with forwarding
    do_reset();
    cyc("lw x5", 1, 1, 1, 2, 0, 0, 1, 5, 1, 0, 10'h0, 0);
    chk("lu_lw_issue", if_b.issue, 1);
    cyc("add x6,x5,x1", 1, 1, 1, 5, 1, 1, 1, 6, 0, 0, 10'h0, 0);
    chk("lu_stall_id", if_b.stall_id, 1);
    chk("lu_stall_if", if_b.stall_if, 1);
    chk("lu_issue0", if_b.issue, 0);
    cyc("add x6 retry", 1, 1, 1, 5, 1, 1, 1, 6, 0, 0, 10'h0, 0);
    chk("lu_issue1", if_b.issue, 1);
    chk("lu_stall_clr", if_b.stall_id, 0);
    idle("idle");
    chk("lu_haz_cnt", if_b.haz_cycles, 1);
    cyc("addi x7", 1, 1, 1, 0, 0, 0, 1, 7, 0, 0, 10'h0, 0);
    chk("alu_issue", if_b.issue, 1);
    cyc("add x8,x7", 1, 1, 1, 7, 0, 0, 1, 8, 0, 0, 10'h0, 0);
    chk("fwd_alu_no_stall", if_b.issue, 1);
    chk("nofwd_alu_stall", if_a.issue, 0);

    // 3: no forwarding, EX and MEM matches stall, WB match and x0 do not
    do_reset();
    cyc("addi x3", 1, 1, 1, 0, 0, 0, 1, 3, 0, 0, 10'h0, 0);
    chk("nf_prod_issue", if_a.issue, 1);
    cyc("add x4 (EX)", 1, 1, 1, 3, 1, 3, 1, 4, 0, 0, 10'h0, 0);
    chk("nf_ex_stall", if_a.stall_id, 1);
    chk("nf_ex_issue", if_a.issue, 0);
    cyc("add x4 (MEM)", 1, 1, 1, 3, 1, 3, 1, 4, 0, 0, 10'h0, 0);
    chk("nf_mem_stall", if_a.stall_id, 1);
    chk("nf_mem_stall_if", if_a.stall_if, 1);
    cyc("add x4 (WB)", 1, 1, 1, 3, 1, 3, 1, 4, 0, 0, 10'h0, 0);
    chk("nf_wb_issue", if_a.issue, 1);
    chk("nf_wb_nostall", if_a.stall_id, 0);
    chk("nf_haz_cnt1", if_a.haz_cycles, 1);
    idle("idle");
    chk("nf_haz_cnt2", if_a.haz_cycles, 2);
    cyc("addi x0", 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 10'h0, 0);
    chk("x0_prod_issue", if_a.issue, 1);
    cyc("add x5,x0,x4", 1, 1, 1, 0, 1, 4, 1, 5, 0, 0, 10'h0, 0);
    chk("x0_wb_issue", if_a.issue, 1);
    chk("x0_wb_nostall", if_a.stall_id, 0);

    // 4: taken branch beats a hazard
    do_reset();
    cyc("addi x3", 1, 1, 1, 0, 0, 0, 1, 3, 0, 0, 10'h0, 0);
    cyc("br + add x4,x3", 1, 1, 1, 3, 0, 0, 1, 4, 0, 1, 10'h1A4, 0);
    chk("br_redir_en", if_a.pc_redirect_en, 1);
    chk("br_redir", if_a.pc_redirect, 10'h1A4);
    chk("br_flush", if_a.flush_id, 1);
    chk("br_issue", if_a.issue, 0);
    chk("br_stall_id", if_a.stall_id, 0);
    idle("after br");
    chk("br_redir_en_off", if_a.pc_redirect_en, 0);
    chk("br_redir_zero", if_a.pc_redirect, 0);
    chk("br_flush_off", if_a.flush_id, 0);
    idle("after br 2");
    chk("br_no_haz_cnt", if_a.haz_cycles, 0);

    // 5: mem_busy freeze in the middle of a hazard stall
    do_reset();
    cyc("addi x3", 1, 1, 1, 0, 0, 0, 1, 3, 0, 0, 10'h0, 0);
    cyc("add stall", 1, 1, 1, 3, 0, 0, 1, 4, 0, 0, 10'h0, 0);
    chk("mb_pre_stall", if_a.stall_id, 1);
    chk("mb_pre_stall_ex", if_a.stall_ex, 0);
    cyc("busy1", 1, 1, 1, 3, 0, 0, 1, 4, 0, 0, 10'h0, 1);
    chk("mb1_stall_ex", if_a.stall_ex, 1);
    chk("mb1_stall_if", if_a.stall_if, 1);
    chk("mb1_issue", if_a.issue, 0);
    cyc("busy2", 1, 1, 1, 3, 0, 0, 1, 4, 0, 0, 10'h0, 1);
    chk("mb2_stall_ex", if_a.stall_ex, 1);
    cyc("busy3", 1, 1, 1, 3, 0, 0, 1, 4, 0, 0, 10'h0, 1);
    chk("mb3_stall_ex", if_a.stall_ex, 1);
    chk("mb3_mem_cnt", if_a.mem_cycles, 1);
    cyc("resume", 1, 1, 1, 3, 0, 0, 1, 4, 0, 0, 10'h0, 0);
    chk("mb_resume_stall", if_a.stall_id, 1);
    chk("mb_resume_ex", if_a.stall_ex, 0);
    chk("mb_resume_cnt", if_a.mem_cycles, 2);
    cyc("issue", 1, 1, 1, 3, 0, 0, 1, 4, 0, 0, 10'h0, 0);
    chk("mb_issue", if_a.issue, 1);
    chk("mb_mem_cnt3", if_a.mem_cycles, 3);
    chk("mb_haz_cnt1", if_a.haz_cycles, 1);
    idle("idle");
    chk("mb_haz_cnt2", if_a.haz_cycles, 2);
    chk("mb_mem_hold", if_a.mem_cycles, 3);

    // 6: 22 hazard cycles into a 4-bit counter
    do_reset();
    for (int k = 0; k < 11; k++) begin
      cyc("sat prod", 1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 10'h0, 0);
      chk("sat_cnt", if_a.haz_cycles, (2 * k > 15) ? 15 : 2 * k);
      cyc("sat use", 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 10'h0, 0);
      chk("sat_stall", if_a.stall_id, 1);
      cyc("sat use", 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 10'h0, 0);
      cyc("sat use", 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 10'h0, 0);
      chk("sat_issue", if_a.issue, 1);
    end
    idle("idle");
    chk("sat_final", if_a.haz_cycles, 4'hF);
    idle("idle");
    chk("sat_hold", if_a.haz_cycles, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
